// File: rtl/sd_clock_gen.sv
// SD-card bus clock generator: registered 50%-duty sclk at slow, fast or programmable
// rate. Rate switching and parking only happen at a falling edge, so sclk never glitches.
module sd_clock_gen #(
    parameter int CNT_W    = 8,
    parameter int DIV_SLOW = 60,
    parameter int DIV_FAST = 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clk_en,
    input  logic [1:0]       sel,
    input  logic [CNT_W-1:0] div_val,
    output logic             sclk,
    output logic             sclk_rise,
    output logic             sclk_fall,
    output logic             rate_ack,
    output logic             parked
);

    typedef enum logic [1:0] {
        PARKED   = 2'd0,
        RUN_LOW  = 2'd1,
        RUN_HIGH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] DIV_SLOW_C = CNT_W'(DIV_SLOW);
    localparam logic [CNT_W-1:0] DIV_FAST_C = CNT_W'(DIV_FAST);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] active_div_q;
    logic             sclk_q;
    logic             rise_q;
    logic             fall_q;
    logic             ack_q;
    logic             parked_q;

    logic [CNT_W-1:0] req_div;
    logic             req_run;
    logic             terminal;

    always_comb begin
        req_div = DIV_SLOW_C;
        case (sel)
            2'b01:   req_div = DIV_FAST_C;
            2'b10:   req_div = (div_val == '0) ? ONE : div_val;
            default: req_div = DIV_SLOW_C;
        endcase
        req_run = clk_en && (sel != 2'b11);
    end

    // active_div is never 0, so subtracting one cannot wrap
    assign terminal = (cnt_q == (active_div_q - ONE));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= PARKED;
            cnt_q        <= '0;
            active_div_q <= DIV_SLOW_C;
            sclk_q       <= 1'b0;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
            ack_q        <= 1'b0;
            parked_q     <= 1'b1;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            ack_q  <= 1'b0;
            case (state_q)
                PARKED: begin
                    sclk_q       <= 1'b0;
                    cnt_q        <= '0;
                    active_div_q <= req_div;
                    ack_q        <= (req_div != active_div_q);
                    if (req_run) begin
                        state_q  <= RUN_LOW;
                        parked_q <= 1'b0;
                    end else begin
                        parked_q <= 1'b1;
                    end
                end
                RUN_LOW: begin
                    if (terminal) begin
                        cnt_q   <= '0;
                        sclk_q  <= 1'b1;
                        rise_q  <= 1'b1;
                        state_q <= RUN_HIGH;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                RUN_HIGH: begin
                    if (terminal) begin
                        // falling edge: the only safe point to change rate or park
                        cnt_q        <= '0;
                        sclk_q       <= 1'b0;
                        fall_q       <= 1'b1;
                        active_div_q <= req_div;
                        ack_q        <= (req_div != active_div_q);
                        if (req_run) begin
                            state_q <= RUN_LOW;
                        end else begin
                            state_q  <= PARKED;
                            parked_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                default: begin
                    state_q  <= PARKED;
                    cnt_q    <= '0;
                    sclk_q   <= 1'b0;
                    parked_q <= 1'b1;
                end
            endcase
        end
    end

    assign sclk      = sclk_q;
    assign sclk_rise = rise_q;
    assign sclk_fall = fall_q;
    assign rate_ack  = ack_q;
    assign parked    = parked_q;

endmodule

// File: tb/tb_sd_clock_gen.sv
// Directed bench for sd_clock_gen: edge timing per rate, safe switching, park/unpark, async reset.
module tb_sd_clock_gen;

    logic       clk;
    logic       n_rst;
    logic       clk_en;
    logic [1:0] sel;
    logic [7:0] div_val;
    logic       sclk;
    logic       sclk_rise;
    logic       sclk_fall;
    logic       rate_ack;
    logic       parked;

    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;
    int both_cnt = 0;

    sd_clock_gen #(.CNT_W(8), .DIV_SLOW(60), .DIV_FAST(1)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .clk_en    (clk_en),
        .sel       (sel),
        .div_val   (div_val),
        .sclk      (sclk),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .rate_ack  (rate_ack),
        .parked    (parked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rate_ack === 1'b1) ack_cnt++;
        if (sclk_rise === 1'b1 && sclk_fall === 1'b1) both_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Number of clk edges until the chosen strobe is seen (capped at max).
    task automatic wait_edge(input bit want_fall, input int max, output int n);
        logic s;
        n = 0;
        do begin
            tick();
            n++;
            s = want_fall ? sclk_fall : sclk_rise;
        end while (s !== 1'b1 && n < max);
    endtask

    initial begin
        int n;
        int a0;
        int bad;

        n_rst   = 1'b0;
        clk_en  = 1'b1;
        sel     = 2'b00;
        div_val = 8'd0;
        tick();
        tick();
        chk("rst_sclk",   sclk, 0);
        chk("rst_rise",   sclk_rise, 0);
        chk("rst_fall",   sclk_fall, 0);
        chk("rst_ack",    rate_ack, 0);
        chk("rst_parked", parked, 1);

        // slow rate from reset
        n_rst = 1'b1;
        wait_edge(0, 200, n);
        chk("slow_first_rise", n, 61);
        chk("slow_run_parked", parked, 0);
        chk("slow_sclk_hi", sclk, 1);
        wait_edge(1, 200, n);
        chk("slow_high", n, 60);
        chk("slow_sclk_lo", sclk, 0);
        wait_edge(0, 200, n);
        chk("slow_low", n, 60);
        chk("slow_no_ack", ack_cnt, 0);

        // switch to fast mid-high
        repeat (30) tick();
        sel = 2'b01;
        wait_edge(1, 200, n);
        chk("fast_sw_high_len", n, 30);
        chk("fast_sw_ack", rate_ack, 1);
        tick();
        chk("fast_rise1", sclk_rise, 1);
        tick();
        chk("fast_fall1", sclk_fall, 1);
        chk("fast_ack_once", rate_ack, 0);
        tick();
        chk("fast_rise2", sclk_rise, 1);
        tick();
        chk("fast_fall2", sclk_fall, 1);

        // custom div 5, then div 0 treated as 1
        sel = 2'b10;
        div_val = 8'd5;
        tick();
        chk("c5_rise_old", sclk_rise, 1);
        tick();
        chk("c5_fall_sw", sclk_fall, 1);
        chk("c5_ack", rate_ack, 1);
        wait_edge(0, 50, n);
        chk("c5_low", n, 5);
        div_val = 8'd0;
        wait_edge(1, 50, n);
        chk("c5_high", n, 5);
        chk("c0_ack", rate_ack, 1);
        tick();
        chk("c0_rise", sclk_rise, 1);
        tick();
        chk("c0_fall", sclk_fall, 1);
        chk("c0_no_ack", rate_ack, 0);

        // back to slow, drop clk_en 3 cycles into the low phase
        sel = 2'b00;
        tick();
        chk("s_rise_fast", sclk_rise, 1);
        tick();
        chk("s_fall_sw", sclk_fall, 1);
        chk("s_ack", rate_ack, 1);
        repeat (3) tick();
        clk_en = 1'b0;
        wait_edge(0, 200, n);
        chk("stop_low_rest", n, 57);
        chk("stop_not_parked_hi", parked, 0);
        wait_edge(1, 200, n);
        chk("stop_high", n, 60);
        chk("stop_parked", parked, 1);
        chk("stop_no_ack", rate_ack, 0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (sclk !== 1'b0 || sclk_rise !== 1'b0) bad++;
        end
        chk("stop_held_low", bad, 0);
        chk("stop_still_parked", parked, 1);

        // unpark, then a brief stop request that is withdrawn before the fall
        clk_en = 1'b1;
        wait_edge(0, 200, n);
        chk("unpark_rise", n, 61);
        repeat (10) tick();
        clk_en = 1'b0;
        repeat (10) tick();
        clk_en = 1'b1;
        wait_edge(1, 200, n);
        chk("blip_high", n, 40);
        chk("blip_no_park", parked, 0);
        wait_edge(0, 200, n);
        chk("blip_low", n, 60);

        // maximum custom divider
        sel = 2'b10;
        div_val = 8'd255;
        wait_edge(1, 200, n);
        chk("c255_high_old", n, 60);
        chk("c255_ack", rate_ack, 1);
        wait_edge(0, 600, n);
        chk("c255_low", n, 255);
        div_val = 8'd3;
        wait_edge(1, 600, n);
        chk("c255_high", n, 255);
        wait_edge(0, 50, n);
        chk("c3_low", n, 3);
        tick();
        chk("c3_sclk_hi", sclk, 1);

        // async reset mid high phase
        #2 n_rst = 1'b0;
        #1;
        chk("arst_sclk",   sclk, 0);
        chk("arst_rise",   sclk_rise, 0);
        chk("arst_fall",   sclk_fall, 0);
        chk("arst_ack",    rate_ack, 0);
        chk("arst_parked", parked, 1);
        sel = 2'b00;
        a0 = ack_cnt;
        #1 n_rst = 1'b1;
        wait_edge(0, 200, n);
        chk("arst_slow_rise", n, 61);
        wait_edge(1, 200, n);
        chk("arst_slow_high", n, 60);
        chk("arst_no_ack", ack_cnt, a0);

        chk("never_both_strobes", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_clock_gen.md
Name: sd_clock_gen

Overview:
- Parametrised SD-card bus clock generator; successor to the fixed two-rate SD clock divider.
- Produces a registered 50%-duty sclk from the system clock at three rates: slow init rate, fast transfer rate, or a runtime-programmable rate.
- Adds glitch-free rate switching, clock stop/park, and one-cycle edge strobes so the SD command and data FSMs can launch and sample on sclk edges.

Parameters:
- CNT_W, 8, width of the half-period counter and of div_val.
- DIV_SLOW, 60, slow-mode half-period in clk cycles. With a 48 MHz clk this gives 400 kHz.
- DIV_FAST, 1, fast-mode half-period in clk cycles. With a 48 MHz clk this gives 24 MHz.

Ports:
- clk  input  1  system clock. One clock domain only.
- n_rst  input  1  reset, asynchronous, active-low.
- clk_en  input  1  1 = run sclk; 0 = park sclk low.
- sel  input  2  rate select: 00 slow, 01 fast, 10 custom (div_val), 11 stop.
- div_val  input  CNT_W  custom half-period in clk cycles. 0 is treated as 1.
- sclk  output  1  SD bus clock, registered.
- sclk_rise  output  1  one-cycle pulse, high in the first clk cycle that sclk=1.
- sclk_fall  output  1  one-cycle pulse, high in the first clk cycle that sclk=0 after a high phase.
- rate_ack  output  1  one-cycle pulse, high in the cycle a new half-period becomes active.
- parked  output  1  1 while sclk is held low by stop or clk_en=0.

Behaviour:
- Reset (async, n_rst=0):
  - sclk=0, sclk_rise=0, sclk_fall=0, rate_ack=0.
  - parked=1, cnt=0, active_div=DIV_SLOW.
- Requested divider (combinational, from sel):
  - req_div = DIV_SLOW, DIV_FAST, or max(div_val,1) for sel=00/01/10.
  - req_run = clk_en && (sel != 11).
- State machine: PARKED, RUN_LOW, RUN_HIGH.
- PARKED:
  - sclk=0, cnt held 0, parked=1.
  - active_div <= req_div every cycle. rate_ack pulses whenever this changes its value.
  - When req_run=1, go to RUN_LOW next cycle with cnt=0 and parked=0.
- RUN_LOW / RUN_HIGH:
  - cnt increments each cycle.
  - When cnt == active_div-1: cnt <= 0 and sclk toggles. So each half-phase lasts exactly active_div clk cycles and the period is 2*active_div.
- RUN_LOW terminal count: sclk goes 1, enter RUN_HIGH, sclk_rise=1 in that first high cycle.
- RUN_HIGH terminal count:
  - sclk goes 0 and sclk_fall=1 in the first low cycle.
  - If req_run=0, enter PARKED. Otherwise enter RUN_LOW.
  - In the same cycle, active_div <= req_div. If the value differs, rate_ack pulses.
- Safe switching point: the divider changes only at a falling edge or while PARKED.
  - A high phase is never shortened or lengthened, so there are no runt pulses.
  - The low phase that follows a switch uses the new half-period.
- Stop request (sel=11 or clk_en=0) during RUN_LOW or RUN_HIGH:
  - The current low phase (if any) and the next full high phase complete.
  - sclk then parks low after the fall.
  - If req_run returns to 1 before that fall, no park occurs.
- First rising edge after leaving PARKED: active_div cycles after entering RUN_LOW.
- sel or div_val changes mid-phase: ignored until the next safe point. Only the value present at that point is used.
- div_val=1 in custom mode: same as fast mode. sclk toggles every cycle, and sclk_rise/sclk_fall alternate every cycle.
- Strobe timing: sclk_rise and sclk_fall are registered together with sclk and are never high in the same cycle.
- Counter width: cnt is CNT_W bits. div_val up to 2^CNT_W-1 must work, and the terminal compare must not wrap.
- Reset asserted mid-phase: immediately returns to the reset values above.

Test Plan:
- Reset release, clk_en=1, sel=00 -> first sclk_rise 61 cycles after reset release (1 cycle PARKED->RUN_LOW plus 60 low); sclk period 120 cycles, 60 high/60 low; rate_ack never pulses.
- Running slow, sel changed to 01 in the middle of a high phase -> high phase still lasts 60 cycles; rate_ack pulses with sclk_fall; sclk then toggles every cycle (period 2).
- sel=10, div_val=5 from fast mode -> after the next fall, phases are 5 cycles each; div_val=0 -> phases of 1 cycle.
- clk_en dropped 3 cycles into a low phase at div 60 -> low phase completes, one full 60-cycle high follows, sclk_fall pulses, parked=1, sclk stays 0.
- clk_en dropped and then restored before the fall -> no park; sclk stays continuous with an unchanged period.
- n_rst asserted while sclk=1 in custom mode -> sclk=0 and all strobes 0 asynchronously; after release, runs at DIV_SLOW.
